// File: rtl/rename_regfile_mp_pkg.sv
// rtl/rename_regfile_mp_pkg.sv - shared widths and types for the renaming register file
package rename_regfile_mp_pkg;

  localparam int XLEN         = 32;
  localparam int REG_WIDTH    = 5;
  localparam int ROB_WIDTH    = 4;
  localparam int READ_PORTS   = 4;
  localparam int ISSUE_WIDTH  = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int NREG         = 1 << REG_WIDTH;

  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [REG_WIDTH-1:0] reg_t;
  typedef logic [ROB_WIDTH-1:0] tag_t;

  localparam reg_t REG_ZERO = '0;

endpackage

// File: rtl/rename_regfile_mp_if.sv
// rtl/rename_regfile_mp_if.sv - dispatcher/ROB-facing bus of the renaming register file
interface rename_regfile_mp_if;
  import rename_regfile_mp_pkg::*;

  logic                              clrIn;
  logic                              rdyIn;
  logic [ISSUE_WIDTH-1:0]            issueFlag;
  logic [ISSUE_WIDTH*REG_WIDTH-1:0]  issueReg;
  logic [ISSUE_WIDTH*ROB_WIDTH-1:0]  issueROB;
  logic [READ_PORTS*REG_WIDTH-1:0]   rdFlag;
  logic [READ_PORTS-1:0]             rdBusy;
  logic [READ_PORTS*XLEN-1:0]        rdData;
  logic [READ_PORTS*ROB_WIDTH-1:0]   rdRename;
  logic [COMMIT_WIDTH-1:0]           writeFlag;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] writeSrc;
  logic [COMMIT_WIDTH*REG_WIDTH-1:0] writeReg;
  logic [COMMIT_WIDTH*XLEN-1:0]      writeData;

  modport master (
    output clrIn, rdyIn, issueFlag, issueReg, issueROB, rdFlag,
    output writeFlag, writeSrc, writeReg, writeData,
    input  rdBusy, rdData, rdRename
  );

  modport slave (
    input  clrIn, rdyIn, issueFlag, issueReg, issueROB, rdFlag,
    input  writeFlag, writeSrc, writeReg, writeData,
    output rdBusy, rdData, rdRename
  );

endinterface

// File: rtl/rename_regfile_mp_rf_read_port.sv
// rtl/rename_regfile_mp_rf_read_port.sv - one operand lookup with same-cycle commit bypass
module rf_read_port
  import rename_regfile_mp_pkg::*;
(
  input  reg_t                              rdReg,
  input  xlen_t                             regData,
  input  logic                              regBusy,
  input  tag_t                              regTag,
  input  logic [COMMIT_WIDTH-1:0]           writeFlag,
  input  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] writeSrc,
  input  logic [COMMIT_WIDTH*XLEN-1:0]      writeData,
  output logic                              busy,
  output xlen_t                             data,
  output tag_t                              rename
);

  logic  hit;
  xlen_t bypassData;

  always_comb begin
    hit        = 1'b0;
    bypassData = '0;
    // Ascending scan so the youngest matching commit slot supplies the data
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (writeFlag[c] && (writeSrc[c*ROB_WIDTH +: ROB_WIDTH] == regTag)) begin
        hit        = 1'b1;
        bypassData = writeData[c*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    busy   = 1'b0;
    data   = '0;
    rename = '0;
    if (rdReg != REG_ZERO) begin
      if (regBusy && hit) begin
        data = bypassData;
      end else begin
        busy   = regBusy;
        data   = regData;
        rename = regBusy ? regTag : '0;
      end
    end
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// rtl/rename_regfile_mp.sv - multi-port architectural register file with ROB-tag renaming
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
(
  input logic               clkIn,
  input logic               rstIn,
  rename_regfile_mp_if.slave rf
);

  xlen_t           regData [NREG];
  logic [NREG-1:0] regBusy;
  tag_t            regTag  [NREG];

  assign regData[0] = '0;
  assign regBusy[0] = 1'b0;
  assign regTag[0]  = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    localparam reg_t RIDX = reg_t'(r);

    xlen_t dataQ;
    logic  busyQ;
    tag_t  tagQ;
    logic  commitHit;
    logic  commitClr;
    xlen_t commitData;
    logic  issueHit;
    tag_t  issueTag;

    always_comb begin
      commitHit  = 1'b0;
      commitClr  = 1'b0;
      commitData = dataQ;
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (rf.writeFlag[c] && (rf.writeReg[c*REG_WIDTH +: REG_WIDTH] == RIDX)) begin
          commitHit  = 1'b1;
          commitData = rf.writeData[c*XLEN +: XLEN];
          if (busyQ && (rf.writeSrc[c*ROB_WIDTH +: ROB_WIDTH] == tagQ)) begin
            commitClr = 1'b1;
          end
        end
      end
    end

    always_comb begin
      issueHit = 1'b0;
      issueTag = tagQ;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (rf.issueFlag[i] && (rf.issueReg[i*REG_WIDTH +: REG_WIDTH] == RIDX)) begin
          issueHit = 1'b1;
          issueTag = rf.issueROB[i*ROB_WIDTH +: ROB_WIDTH];
        end
      end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
        dataQ <= '0;
        busyQ <= 1'b0;
        tagQ  <= '0;
      end else if (rf.rdyIn) begin
        if (commitHit) begin
          dataQ <= commitData;
        end
        // A flush still lets commits land above; only rename state is discarded
        if (rf.clrIn) begin
          busyQ <= 1'b0;
          tagQ  <= '0;
        end else if (issueHit) begin
          busyQ <= 1'b1;
          tagQ  <= issueTag;
        end else if (commitClr) begin
          busyQ <= 1'b0;
          tagQ  <= '0;
        end
      end
    end

    assign regData[r] = dataQ;
    assign regBusy[r] = busyQ;
    assign regTag[r]  = tagQ;
  end

  logic [READ_PORTS-1:0]           portBusy;
  logic [READ_PORTS*XLEN-1:0]      portData;
  logic [READ_PORTS*ROB_WIDTH-1:0] portRename;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    reg_t rdReg;
    assign rdReg = rf.rdFlag[p*REG_WIDTH +: REG_WIDTH];

    rf_read_port u_port (
      .rdReg     (rdReg),
      .regData   (regData[rdReg]),
      .regBusy   (regBusy[rdReg]),
      .regTag    (regTag[rdReg]),
      .writeFlag (rf.writeFlag),
      .writeSrc  (rf.writeSrc),
      .writeData (rf.writeData),
      .busy      (portBusy[p]),
      .data      (portData[p*XLEN +: XLEN]),
      .rename    (portRename[p*ROB_WIDTH +: ROB_WIDTH])
    );
  end

  assign rf.rdBusy   = portBusy;
  assign rf.rdData   = portData;
  assign rf.rdRename = portRename;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// tb/tb_rename_regfile_mp.sv - randomized and directed bench for rename_regfile_mp
module tb_rename_regfile_mp;
  import rename_regfile_mp_pkg::*;

  logic clkIn = 1'b0;
  logic rstIn = 1'b0;
  always #5 clkIn = ~clkIn;

  rename_regfile_mp_if rf ();

  rename_regfile_mp dut (
    .clkIn (clkIn),
    .rstIn (rstIn),
    .rf    (rf)
  );

  int vectors     = 0;
  int miscompares = 0;

  xlen_t mData [NREG];
  logic  mBusy [NREG];
  tag_t  mTag  [NREG];

  function automatic logic  obs_busy(int p); return rf.rdBusy[p]; endfunction
  function automatic xlen_t obs_data(int p); return rf.rdData[p*XLEN +: XLEN]; endfunction
  function automatic tag_t  obs_ren(int p);  return rf.rdRename[p*ROB_WIDTH +: ROB_WIDTH]; endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      mData[r] = '0; mBusy[r] = 1'b0; mTag[r] = '0;
    end
  endtask

  task automatic idle();
    rf.clrIn = 1'b0; rf.rdyIn = 1'b1;
    rf.issueFlag = '0; rf.issueReg = '0; rf.issueROB = '0;
    rf.writeFlag = '0; rf.writeSrc = '0; rf.writeReg = '0; rf.writeData = '0;
    rf.rdFlag = '0;
  endtask

  task automatic set_issue(int s, int r, int t);
    rf.issueFlag[s] = 1'b1;
    rf.issueReg[s*REG_WIDTH +: REG_WIDTH] = reg_t'(r);
    rf.issueROB[s*ROB_WIDTH +: ROB_WIDTH] = tag_t'(t);
  endtask

  task automatic set_commit(int s, int r, int t, xlen_t d);
    rf.writeFlag[s] = 1'b1;
    rf.writeReg[s*REG_WIDTH +: REG_WIDTH] = reg_t'(r);
    rf.writeSrc[s*ROB_WIDTH +: ROB_WIDTH] = tag_t'(t);
    rf.writeData[s*XLEN +: XLEN] = d;
  endtask

  task automatic set_read(int p, int r);
    rf.rdFlag[p*REG_WIDTH +: REG_WIDTH] = reg_t'(r);
  endtask

  // Reference lookup: reg 0 reads as zero, a live tag matching any commit bypasses
  task automatic model_read(input int r, output logic b, output xlen_t d, output tag_t t);
    logic hit = 1'b0;
    xlen_t bd = '0;
    b = 1'b0; d = '0; t = '0;
    if (r != 0) begin
      for (int c = 0; c < COMMIT_WIDTH; c++)
        if (rf.writeFlag[c] && rf.writeSrc[c*ROB_WIDTH +: ROB_WIDTH] == mTag[r]) begin
          hit = 1'b1; bd = rf.writeData[c*XLEN +: XLEN];
        end
      if (mBusy[r] && hit) d = bd;
      else begin b = mBusy[r]; d = mData[r]; t = mBusy[r] ? mTag[r] : '0; end
    end
  endtask

  // Advance one clock and apply the architectural update rules to the model
  task automatic tick();
    xlen_t nd [NREG];
    logic  nb [NREG];
    tag_t  nt [NREG];
    int    r;
    @(posedge clkIn);
    if (rstIn && rf.rdyIn) begin
      nd = mData; nb = mBusy; nt = mTag;
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        r = int'(rf.writeReg[c*REG_WIDTH +: REG_WIDTH]);
        if (rf.writeFlag[c] && r != 0) begin
          nd[r] = rf.writeData[c*XLEN +: XLEN];
          if (mBusy[r] && mTag[r] == rf.writeSrc[c*ROB_WIDTH +: ROB_WIDTH]) begin
            nb[r] = 1'b0; nt[r] = '0;
          end
        end
      end
      if (rf.clrIn) begin
        for (int k = 0; k < NREG; k++) begin nb[k] = 1'b0; nt[k] = '0; end
      end else begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          r = int'(rf.issueReg[i*REG_WIDTH +: REG_WIDTH]);
          if (rf.issueFlag[i] && r != 0) begin
            nb[r] = 1'b1; nt[r] = rf.issueROB[i*ROB_WIDTH +: ROB_WIDTH];
          end
        end
      end
      mData = nd; mBusy = nb; mTag = nt;
    end
    @(negedge clkIn);
  endtask

  task automatic test_reset();
    idle();
    for (int p = 0; p < READ_PORTS; p++) set_read(p, p + 1);
    #1;
    for (int p = 0; p < READ_PORTS; p++) begin
      vectors++;
      if (obs_busy(p) !== 1'b0 || obs_data(p) !== '0 || obs_ren(p) !== '0) begin
        miscompares++;
        $display("FAIL reset_init port%0d: got busy=%b data=%h rename=%h, expected all 0",
                 p, obs_busy(p), obs_data(p), obs_ren(p));
      end
    end
    @(negedge clkIn);
    rstIn = 1'b1;
    // Build nonzero state, then drop reset mid-cycle
    idle(); set_issue(0, 5, 4); tick();
    idle(); set_commit(0, 5, 4, 32'h1234); set_issue(0, 14, 8); tick();
    idle(); set_read(0, 5); set_read(1, 14); set_read(2, 5); set_read(3, 14);
    #2 rstIn = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < READ_PORTS; p++) begin
      vectors++;
      if (obs_busy(p) !== 1'b0 || obs_data(p) !== '0 || obs_ren(p) !== '0) begin
        miscompares++;
        $display("FAIL reset_async port%0d: got busy=%b data=%h rename=%h, expected all 0",
                 p, obs_busy(p), obs_data(p), obs_ren(p));
      end
    end
    @(negedge clkIn);
    rstIn = 1'b1;
    #1;
    vectors++;
    if (obs_busy(0) !== 1'b0 || obs_data(0) !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release_x5: got busy=%b data=%h, expected busy=0 data=0", obs_busy(0), obs_data(0));
    end
    tick();
  endtask

  task automatic test_issue_commit();
    idle(); set_issue(0, 3, 7); tick();
    idle(); set_read(0, 3); #1;
    vectors++;
    if (obs_busy(0) !== 1'b1 || obs_ren(0) !== 4'd7) begin
      miscompares++;
      $display("FAIL issue_x3: got busy=%b rename=%0d, expected busy=1 rename=7", obs_busy(0), obs_ren(0));
    end
    set_commit(0, 3, 7, 32'hDEAD); #1;
    vectors++;
    if (obs_busy(0) !== 1'b0 || obs_data(0) !== 32'hDEAD) begin
      miscompares++;
      $display("FAIL bypass_x3: got busy=%b data=%h, expected busy=0 data=0000dead", obs_busy(0), obs_data(0));
    end
    tick();
    idle(); set_read(0, 3); #1;
    vectors++;
    if (obs_busy(0) !== 1'b0 || obs_data(0) !== 32'hDEAD || obs_ren(0) !== 4'd0) begin
      miscompares++;
      $display("FAIL commit_x3: got busy=%b data=%h rename=%0d, expected 0/0000dead/0",
               obs_busy(0), obs_data(0), obs_ren(0));
    end
  endtask

  task automatic test_same_reg_issue();
    idle(); set_issue(0, 4, 2); set_issue(1, 4, 3); tick();
    idle(); set_read(0, 4); #1;
    vectors++;
    if (obs_busy(0) !== 1'b1 || obs_ren(0) !== 4'd3) begin
      miscompares++;
      $display("FAIL dual_issue_x4: got busy=%b rename=%0d, expected busy=1 rename=3", obs_busy(0), obs_ren(0));
    end
    set_commit(0, 4, 2, 32'h11); tick();
    idle(); set_read(0, 4); #1;
    vectors++;
    if (obs_busy(0) !== 1'b1 || obs_data(0) !== 32'h11 || obs_ren(0) !== 4'd3) begin
      miscompares++;
      $display("FAIL stale_commit_x4: got busy=%b data=%h rename=%0d, expected 1/00000011/3",
               obs_busy(0), obs_data(0), obs_ren(0));
    end
  endtask

  task automatic test_commit_vs_issue();
    idle(); set_issue(0, 6, 1); tick();
    idle(); set_commit(0, 6, 1, 32'h66); set_issue(1, 6, 9); tick();
    idle(); set_read(0, 6); #1;
    vectors++;
    if (obs_busy(0) !== 1'b1 || obs_ren(0) !== 4'd9 || obs_data(0) !== 32'h66) begin
      miscompares++;
      $display("FAIL issue_over_clear_x6: got busy=%b data=%h rename=%0d, expected 1/00000066/9",
               obs_busy(0), obs_data(0), obs_ren(0));
    end
  endtask

  task automatic test_flush();
    idle(); set_issue(0, 7, 1); set_issue(1, 8, 2); tick();
    idle(); set_issue(0, 9, 3); set_issue(1, 10, 4); tick();
    idle(); rf.clrIn = 1'b1; set_commit(0, 8, 5, 32'h55); set_issue(0, 11, 6); tick();
    idle(); set_read(0, 7); set_read(1, 8); set_read(2, 10); set_read(3, 11); #1;
    for (int p = 0; p < READ_PORTS; p++) begin
      vectors++;
      if (obs_busy(p) !== 1'b0 || obs_ren(p) !== 4'd0) begin
        miscompares++;
        $display("FAIL flush_busy port%0d: got busy=%b rename=%0d, expected busy=0 rename=0",
                 p, obs_busy(p), obs_ren(p));
      end
    end
    vectors++;
    if (obs_data(1) !== 32'h55) begin
      miscompares++;
      $display("FAIL flush_commit_x8: got data=%h, expected 00000055", obs_data(1));
    end
  endtask

  task automatic test_hold_and_x0();
    idle(); set_issue(0, 12, 5); tick();
    idle(); rf.rdyIn = 1'b0; set_issue(0, 13, 2); set_commit(0, 12, 5, 32'hAA); tick();
    idle(); set_read(0, 12); set_read(1, 13); #1;
    vectors++;
    if (obs_busy(0) !== 1'b1 || obs_ren(0) !== 4'd5 || obs_data(0) !== 32'h0 || obs_busy(1) !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_rdy0: got x12 busy=%b rename=%0d data=%h x13 busy=%b, expected 1/5/0 and 0",
               obs_busy(0), obs_ren(0), obs_data(0), obs_busy(1));
    end
    idle(); set_issue(0, 0, 3); set_commit(0, 0, 0, 32'hFF); set_read(0, 0); #1;
    vectors++;
    if (obs_busy(0) !== 1'b0 || obs_data(0) !== 32'h0 || obs_ren(0) !== 4'd0) begin
      miscompares++;
      $display("FAIL x0_same_cycle: got busy=%b data=%h rename=%0d, expected 0/0/0",
               obs_busy(0), obs_data(0), obs_ren(0));
    end
    tick();
    idle(); set_read(0, 0); #1;
    vectors++;
    if (obs_busy(0) !== 1'b0 || obs_data(0) !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_after: got busy=%b data=%h, expected 0/0", obs_busy(0), obs_data(0));
    end
  endtask

  task automatic test_random();
    logic  eb;
    xlen_t ed;
    tag_t  et;
    int    r;
    int    rr;
    for (int n = 0; n < 400; n++) begin
      idle();
      rf.rdyIn = ($urandom_range(0, 9) != 0);
      rf.clrIn = ($urandom_range(0, 19) == 0);
      for (int s = 0; s < ISSUE_WIDTH; s++)
        if ($urandom_range(0, 1) == 1) set_issue(s, $urandom_range(0, 7), $urandom_range(0, 15));
      for (int c = 0; c < COMMIT_WIDTH; c++)
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          set_commit(c, r, ($urandom_range(0, 3) != 0) ? int'(mTag[r]) : $urandom_range(0, 15), $urandom);
        end
      for (int p = 0; p < READ_PORTS; p++) set_read(p, $urandom_range(0, 7));
      #1;
      for (int p = 0; p < READ_PORTS; p++) begin
        rr = int'(rf.rdFlag[p*REG_WIDTH +: REG_WIDTH]);
        model_read(rr, eb, ed, et);
        vectors++;
        if (obs_busy(p) !== eb || obs_data(p) !== ed || obs_ren(p) !== et) begin
          miscompares++;
          $display("FAIL rand_read cyc%0d port%0d x%0d: got busy=%b data=%h rename=%0d, expected busy=%b data=%h rename=%0d",
                   n, p, rr, obs_busy(p), obs_data(p), obs_ren(p), eb, ed, et);
        end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    idle();
    @(negedge clkIn);
    test_reset();
    test_issue_commit();
    test_same_reg_issue();
    test_commit_vs_issue();
    test_flush();
    test_hold_and_x0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
